ipgu_raster_loader: RTL and testbench
=====================================

IPGU_RASTER_LOADER -- requirements
Module: ipgu_raster_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter DEPTH_X, default 300: image width in pixels.
REQ-003 SHALL have parameter DEPTH_Y, default 300: image height in pixels.
REQ-004 SHALL have parameter ADDR_WIDTH_X, default $clog2(DEPTH_X): column address width.
REQ-005 SHALL have parameter ADDR_WIDTH_Y, default $clog2(DEPTH_Y): row address width.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic rises on posedge clk.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: begin a frame load.
REQ-009 SHALL have port abort, input, 1: cancel the load in progress.
REQ-010 SHALL have port busy, output, 1: high while not IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the frame is fully written.
REQ-012 SHALL have port pix_valid, input, 1: upstream pixel valid.
REQ-013 SHALL have port pix_ready, output, 1: loader accepts a pixel.
REQ-014 SHALL have port pix_data, input, DATA_WIDTH: pixel value in raster order.
REQ-015 SHALL have port ram_addr, output, ADDR_WIDTH_X+ADDR_WIDTH_Y: RAM address {y,x}, with x in the low bits.
REQ-016 SHALL have ports ram_wrData (output, DATA_WIDTH), ram_cs (output, 1), ram_we (output, 1) and ram_wrAll (output, 1): the downstream RAM write port.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR (macro only) and LOAD, encoded in a 2-bit register.
REQ-018 IDLE with start=1 SHALL zero x/y and enter CLEAR if IPGU_LOADER_CLEAR_EN is defined, else LOAD.
REQ-019 start SHALL be ignored whenever busy=1.
REQ-020 pix_ready SHALL equal (state==LOAD), decoded combinationally from state only.
REQ-021 A pixel SHALL be accepted on the clk edge where pix_valid and pix_ready are both 1.
REQ-022 An accept at edge N SHALL drive, from edge N until edge N+1: ram_cs=1, ram_we=1, ram_addr={y,x}, ram_wrData=pix_data. Outputs are registered; latency is 1 cycle.
REQ-023 After each accept, x SHALL increment; at x==DEPTH_X-1, x SHALL wrap to 0 and y SHALL increment.
REQ-024 Accepting pixel (DEPTH_X-1, DEPTH_Y-1) SHALL move state to IDLE and SHALL assert done for exactly the cycle its write is presented.
REQ-025 A cycle with no accept and no clear write SHALL drive ram_cs=0 and ram_we=0; ram_addr and ram_wrData hold their last values.
REQ-026 ram_wrAll SHALL be constant 0.
REQ-027 abort=1 while busy SHALL, at the next edge, return state to IDLE and zero x/y, with no done pulse.
REQ-028 A pixel accepted on the abort edge SHALL still be written per REQ-022.
REQ-029 abort=1 in IDLE SHALL have no effect.
REQ-030 abort SHALL have priority over start in the same cycle.
REQ-031 pix_valid with pix_ready=0 SHALL NOT consume the pixel or advance the counters.

Reset
REQ-032 While rst_n=0, asynchronously: state=IDLE, x=y=0, busy=0, done=0, ram_cs=0, ram_we=0, ram_addr=0, ram_wrData=0.
REQ-033 Reset mid-frame SHALL discard progress; the first write after a new start SHALL target address 0.

Configuration
REQ-034 With macro IPGU_LOADER_CLEAR_EN defined, CLEAR SHALL write 0 to every address in raster order, one write per cycle (DEPTH_X*DEPTH_Y cycles), with pix_ready=0 throughout.
REQ-035 After the last clear write (address {DEPTH_Y-1,DEPTH_X-1}), the block SHALL zero x/y and enter LOAD; abort in CLEAR SHALL follow REQ-027.
REQ-036 With IPGU_LOADER_CLEAR_EN undefined, the CLEAR state and its logic SHALL be absent, and start SHALL go directly to LOAD.

Verification (DEPTH_X=4, DEPTH_Y=3, macro undefined unless stated)
REQ-037 start, then 12 back-to-back pixels 0x10..0x1B -> 12 writes at addresses 0x00,0x01,0x02,0x03,0x04..0x0B ({y,x} with 2-bit x), data 0x10..0x1B; done pulses once with the 0x1B write; busy falls the same edge.
REQ-038 pix_valid toggling 1,0,1,0 -> writes only on accept edges, ram_cs=0 in gaps, addresses contiguous.
REQ-039 abort after 5 accepts -> IDLE the next edge, no done; the next start writes its first pixel to address 0.
REQ-040 rst_n pulled low mid-write (ram_cs=1) -> ram_cs, ram_we, busy and pix_ready drop immediately, without waiting for a clk edge.
REQ-041 start while busy -> ignored, and the counters are unaffected.
REQ-042 Macro defined: start -> 12 zero-writes over 12 cycles with pix_ready=0, then pixels are accepted starting at address 0.

Source files
------------

// File: rtl/ipgu_raster_loader.sv
// ipgu_raster_loader
//   Streams a frame of pixels, arriving in raster order over a valid/ready
//   handshake, into a downstream RAM write port. Each accepted pixel is
//   written at {y,x} one cycle later; done pulses with the final write.
//
// Optional feature: define IPGU_LOADER_CLEAR_EN to insert a CLEAR pass that
//   writes zero to every address before pixels are accepted.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, abort       : begin a frame load / cancel the load in progress
//   busy, done         : not-idle flag / one-cycle frame-complete pulse
//   pix_valid, pix_ready, pix_data : upstream pixel handshake
//   ram_addr ({y,x}), ram_wrData, ram_cs, ram_we, ram_wrAll : RAM write port
module ipgu_raster_loader #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_X      = 300,
    parameter int DEPTH_Y      = 300,
    parameter int ADDR_WIDTH_X = $clog2(DEPTH_X),
    parameter int ADDR_WIDTH_Y = $clog2(DEPTH_Y)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    output logic                               busy,
    output logic                               done,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    input  logic [DATA_WIDTH-1:0]              pix_data,
    output logic [ADDR_WIDTH_X+ADDR_WIDTH_Y-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_wrData,
    output logic                               ram_cs,
    output logic                               ram_we,
    output logic                               ram_wrAll
);

`ifdef IPGU_LOADER_CLEAR_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CLEAR = 2'd2} state_t;
    localparam state_t START_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1} state_t;
    localparam state_t START_STATE = LOAD;
`endif

    localparam logic [ADDR_WIDTH_X-1:0] X_LAST = ADDR_WIDTH_X'(DEPTH_X - 1);
    localparam logic [ADDR_WIDTH_Y-1:0] Y_LAST = ADDR_WIDTH_Y'(DEPTH_Y - 1);

    state_t                  state;
    logic [ADDR_WIDTH_X-1:0] x;
    logic [ADDR_WIDTH_Y-1:0] y;
    logic [ADDR_WIDTH_X-1:0] x_nxt;
    logic [ADDR_WIDTH_Y-1:0] y_nxt;
    logic                    frame_last;

    // Raster-order successor of the current coordinate.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x_nxt      = x + 1'b1;
        y_nxt      = y;
        frame_last = (x == X_LAST) && (y == Y_LAST);
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign pix_ready = (state == LOAD);
    assign ram_wrAll = 1'b0;

    // NOTE: sequential state uses non-blocking assignments only; later
    // assignments in the same block deliberately override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            done       <= 1'b0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wrData <= '0;
        end else begin
            // Strobes default low; address and data hold between writes.
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // abort wins over start; on its own abort changes nothing here.
                    if (start && !abort) begin
                        x     <= '0;
                        y     <= '0;
                        state <= START_STATE;
                    end
                end
`ifdef IPGU_LOADER_CLEAR_EN
                CLEAR: begin
                    ram_cs     <= 1'b1;
                    ram_we     <= 1'b1;
                    ram_addr   <= {y, x};
                    ram_wrData <= '0;
                    if (abort || frame_last) begin
                        x     <= '0;
                        y     <= '0;
                        state <= abort ? IDLE : LOAD;
                    end else begin
                        x <= x_nxt;
                        y <= y_nxt;
                    end
                end
`endif
                LOAD: begin
                    // A pixel accepted on the abort edge is still written.
                    if (pix_valid) begin
                        ram_cs     <= 1'b1;
                        ram_we     <= 1'b1;
                        ram_addr   <= {y, x};
                        ram_wrData <= pix_data;
                        if (frame_last) begin
                            x     <= '0;
                            y     <= '0;
                            state <= IDLE;
                            done  <= !abort;
                        end else begin
                            x <= x_nxt;
                            y <= y_nxt;
                        end
                    end
                    if (abort) begin
                        x     <= '0;
                        y     <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipgu_raster_loader.sv
// Self-checking bench for ipgu_raster_loader with a 4x3 frame.
module tb_ipgu_raster_loader;
    localparam int DW = 8;
    localparam int DX = 4;
    localparam int DY = 3;
    localparam int AW = 4;
    localparam int NPIX = DX * DY;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          busy, done, pix_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wrData;
    logic          ram_cs, ram_we, ram_wrAll;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          cs;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } wr_t;

    wr_t exp_q[$];

    ipgu_raster_loader #(
        .DATA_WIDTH(DW),
        .DEPTH_X   (DX),
        .DEPTH_Y   (DY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .ram_addr  (ram_addr),
        .ram_wrData(ram_wrData),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wrAll (ram_wrAll)
    );

    always #5 clk = ~clk;

    function automatic wr_t obs();
        return '{cs: ram_cs, we: ram_we, addr: ram_addr, data: ram_wrData, done: done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel and queue the write it must produce.
    task automatic drive_pixel(input int idx, input logic [DW-1:0] d, input logic last);
        pix_valid = 1'b1;
        pix_data  = d;
        exp_q.push_back('{cs: 1'b1, we: 1'b1, addr: AW'(idx), data: d, done: last});
    endtask

    task automatic do_start();
        pix_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef IPGU_LOADER_CLEAR_EN
        repeat (NPIX) tick();
`endif
    endtask

    task automatic test_reset();
        wr_t o;
        rst_n = 1'b0;
        #3;
        o = obs();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", o, wr_t'(0));
        end
        n_checks++;
        if ({busy, pix_ready, ram_wrAll} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=000", {busy, pix_ready, ram_wrAll});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        do_start();
        n_checks++;
        if ({busy, pix_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_ready got=%b exp=11", {busy, pix_ready});
        end
        for (int i = 0; i < NPIX; i++) begin
            drive_pixel(i, DW'(8'h10 + i), i == NPIX - 1);
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_write[%0d] got=%h exp=%h", i, o, e);
            end
        end
        pix_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_fall got=%b exp=0", busy);
        end
        tick();
        o = obs();
        n_checks++;
        if (o !== '{cs: 1'b0, we: 1'b0, addr: AW'(11), data: 8'h1B, done: 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_idle_hold got=%h exp=0%h%h0", o, 4'hB, 8'h1B);
        end
    endtask

    task automatic test_gaps();
        wr_t e, o;
        int k = 0;
        logic drove;
        logic [AW-1:0] last_addr = '0;
        logic [DW-1:0] last_data = '0;
        do_start();
        for (int i = 0; i < 2 * NPIX; i++) begin
            drove = (i % 2 == 0);
            if (drove) begin
                drive_pixel(k, DW'(8'h40 + k), k == NPIX - 1);
                last_addr = AW'(k);
                last_data = DW'(8'h40 + k);
                k++;
            end else begin
                pix_valid = 1'b0;
            end
            tick();
            o = obs();
            n_checks++;
            if (drove) begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL gap_write[%0d] got=%h exp=%h", i, o, e);
                end
            end else if ({o.cs, o.we, o.addr, o.data} !== {2'b00, last_addr, last_data}) begin
                n_fail++;
                $display("FAIL gap_idle[%0d] got=%h exp=00%h%h", i, {o.cs, o.we, o.addr, o.data},
                         last_addr, last_data);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_end_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_abort();
        wr_t e, o;
        do_start();
        for (int i = 0; i < 5; i++) begin
            abort = (i == 4);
            drive_pixel(i, DW'(8'h60 + i), 1'b0);
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_write[%0d] got=%h exp=%h", i, o, e);
            end
        end
        abort = 1'b0;
        pix_valid = 1'b0;
        n_checks++;
        if ({busy, pix_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle got=%b exp=00", {busy, pix_ready});
        end
        tick();
        n_checks++;
        if ({done, ram_cs} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_done got=%b exp=00", {done, ram_cs});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_idle got=%b exp=0", busy);
        end
        do_start();
        drive_pixel(0, 8'hA5, 1'b0);
        tick();
        e = exp_q.pop_front();
        o = obs();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL abort_restart got=%h exp=%h", o, e);
        end
        pix_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_start_busy();
        wr_t e, o;
        do_start();
        for (int i = 0; i < NPIX; i++) begin
            start = (i == 3 || i == 4);
            drive_pixel(i, DW'(8'h80 + i), i == NPIX - 1);
            tick();
            e = exp_q.pop_front();
            o = obs();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL start_busy_write[%0d] got=%h exp=%h", i, o, e);
            end
        end
        start = 1'b0;
        pix_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_end got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        wr_t e, o;
        do_start();
        drive_pixel(0, 8'h77, 1'b0);
        tick();
        e = exp_q.pop_front();
        o = obs();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rst_mid_write got=%h exp=%h", o, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_cs, ram_we, busy, pix_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_async got=%b exp=0000", {ram_cs, ram_we, busy, pix_ready});
        end
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start();
        drive_pixel(0, 8'h88, 1'b0);
        tick();
        e = exp_q.pop_front();
        o = obs();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL rst_mid_restart got=%h exp=%h", o, e);
        end
        pix_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

`ifdef IPGU_LOADER_CLEAR_EN
    task automatic test_clear();
        wr_t e, o;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (pix_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_ready[%0d] got=%b exp=0", i, pix_ready);
            end
            tick();
            o = obs();
            n_checks++;
            if (o !== '{cs: 1'b1, we: 1'b1, addr: AW'(i), data: '0, done: 1'b0}) begin
                n_fail++;
                $display("FAIL clear_write[%0d] got=%h exp=11%h000", i, o, AW'(i));
            end
        end
        drive_pixel(0, 8'h5A, 1'b0);
        tick();
        e = exp_q.pop_front();
        o = obs();
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL clear_then_load got=%h exp=%h", o, e);
        end
        pix_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_start_busy();
        test_reset_mid();
`ifdef IPGU_LOADER_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
